// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl
//   HUB75 panel scan controller. Reads the top-half (bank1) and bottom-half
//   (bank2) RGB565 pixels for one row from the dual-bank pixel RAM. It shifts
//   one bit-plane of that row into the panel, latches it, and then drives OE
//   low for a plane-weighted on-time (binary-code modulation, LSB plane first).
//
// Ports
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_enable             run scanning; dropping it stops at the next plane boundary
//   o_r_addr/o_r_enable  pixel RAM read port {row,col}; data arrives one cycle later
//   i_bank1/2_data       RGB565 pixels for the top/bottom half
//   o_r1..o_b2           colour bits shifted into the panel
//   o_panel_clk          panel shift clock (panel samples on the rising edge)
//   o_latch, o_oe_n      panel latch (active-high), output enable (active-low)
//   o_row                panel row address, updated only while o_latch is high
//   o_frame              one-cycle pulse after the last plane of the last row
//
// Optional feature
//   HUB75_BRIGHTNESS_EN  adds i_brightness[7:0]. It scales the lit part of each
//                        display window. The window length itself stays the same.
module led_scan_ctrl #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 5,
  parameter int PLANES   = 5,
  parameter int BASE_ON  = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]                       i_brightness,
`endif
  output logic [ROW_BITS+$clog2(COLS)-1:0] o_r_addr,
  output logic                             o_r_enable,
  input  logic [15:0]                      i_bank1_data,
  input  logic [15:0]                      i_bank2_data,
  output logic                             o_r1,
  output logic                             o_g1,
  output logic                             o_b1,
  output logic                             o_r2,
  output logic                             o_g2,
  output logic                             o_b2,
  output logic                             o_panel_clk,
  output logic                             o_latch,
  output logic                             o_oe_n,
  output logic [ROW_BITS-1:0]              o_row,
  output logic                             o_frame
);

  localparam int CB   = $clog2(COLS);
  localparam int PB   = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int ON_W = $clog2(BASE_ON << (PLANES - 1)) + 1;

  typedef enum logic [2:0] {S_IDLE, S_PREFETCH, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

  state_t                  state_q, state_d;
  logic                    phase_q, phase_d;
  logic [CB-1:0]           col_q, col_d;
  logic [ROW_BITS-1:0]     row_q, row_d;
  logic [PB-1:0]           plane_q, plane_d;
  logic [ON_W-1:0]         on_cnt_q, on_cnt_d;
  logic [ON_W-1:0]         lit_q, lit_d;
  logic [ROW_BITS+CB-1:0]  r_addr_q, r_addr_d;
  logic                    r_en_q, r_en_d;
  logic [2:0]              rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic                    panel_clk_q, panel_clk_d;
  logic                    latch_q, latch_d;
  logic                    oe_n_q, oe_n_d;
  logic [ROW_BITS-1:0]     row_out_q, row_out_d;
  logic                    frame_q, frame_d;

  logic [ON_W-1:0]         on_len;
  logic [ON_W-1:0]         lit_now;
  logic [3:0]              p_idx;
  logic                    col_last, plane_last, row_last;

  assign on_len     = ON_W'(BASE_ON) << plane_q;
  assign p_idx      = 4'(plane_q);
  assign col_last   = (col_q == CB'(COLS - 1));
  assign plane_last = (plane_q == PB'(PLANES - 1));
  assign row_last   = (row_q == {ROW_BITS{1'b1}});

`ifdef HUB75_BRIGHTNESS_EN
  // Number of lit cycles = window * (brightness+1) / 256, truncated.
  logic [ON_W+8:0] lit_prod;
  assign lit_prod = (ON_W+9)'(on_len) * (ON_W+9)'({1'b0, i_brightness} + 9'd1);
  assign lit_now  = ON_W'(lit_prod >> 8);
`else
  assign lit_now  = on_len;
`endif

  // Output timing of the shift phases: the RAM word for a column is on the
  // bus during phase A and is registered onto the colour pins for phase B.
  // The panel clock rises at the start of the following cycle, so the colour
  // bits have been stable for a full cycle when the panel samples them. The
  // last rising edge coincides with the latch pulse. That is harmless because
  // the panel latch is level-sensitive and captures the data when the pulse falls.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    col_d       = col_q;
    row_d       = row_q;
    plane_d     = plane_q;
    on_cnt_d    = on_cnt_q;
    lit_d       = lit_q;
    r_addr_d    = r_addr_q;
    r_en_d      = 1'b0;
    rgb1_d      = rgb1_q;
    rgb2_d      = rgb2_q;
    panel_clk_d = panel_clk_q;
    latch_d     = latch_q;
    oe_n_d      = oe_n_q;
    row_out_d   = row_out_q;
    frame_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        oe_n_d = 1'b1;
        if (i_enable) begin
          state_d  = S_PREFETCH;
          r_en_d   = 1'b1;
          r_addr_d = {row_q, {CB{1'b0}}};
        end
      end
      S_PREFETCH: begin
        state_d     = S_SHIFT;
        phase_d     = 1'b0;
        col_d       = '0;
        panel_clk_d = 1'b0;
      end
      S_SHIFT: begin
        if (!phase_q) begin
          rgb1_d      = {i_bank1_data[4'd11 + p_idx], i_bank1_data[4'd6 + p_idx], i_bank1_data[p_idx]};
          rgb2_d      = {i_bank2_data[4'd11 + p_idx], i_bank2_data[4'd6 + p_idx], i_bank2_data[p_idx]};
          panel_clk_d = 1'b0;
          phase_d     = 1'b1;
          if (!col_last) begin
            r_en_d   = 1'b1;
            r_addr_d = {row_q, col_q + CB'(1)};
          end
        end else begin
          panel_clk_d = 1'b1;
          phase_d     = 1'b0;
          if (col_last) begin
            state_d   = S_LATCH;
            col_d     = '0;
            latch_d   = 1'b1;
            row_out_d = row_q;
          end else begin
            col_d = col_q + CB'(1);
          end
        end
      end
      S_LATCH: begin
        state_d     = S_DISPLAY;
        panel_clk_d = 1'b0;
        latch_d     = 1'b0;
        on_cnt_d    = '0;
        lit_d       = lit_now;
        oe_n_d      = (lit_now == '0);
      end
      S_DISPLAY: begin
        if (on_cnt_q == on_len - ON_W'(1)) begin
          oe_n_d   = 1'b1;
          on_cnt_d = '0;
          if (plane_last) begin
            plane_d = '0;
            row_d   = row_q + ROW_BITS'(1);
            frame_d = row_last;
          end else begin
            plane_d = plane_q + PB'(1);
          end
          if (i_enable) begin
            state_d  = S_PREFETCH;
            r_en_d   = 1'b1;
            r_addr_d = {row_d, {CB{1'b0}}};
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          on_cnt_d = on_cnt_q + ON_W'(1);
          oe_n_d   = !(on_cnt_d < lit_q);
        end
      end
      default: begin
        state_d = S_IDLE;
        oe_n_d  = 1'b1;
      end
    endcase
  end

  // The asynchronous reset forces OE high at once, even during a lit window.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      plane_q     <= '0;
      on_cnt_q    <= '0;
      lit_q       <= '0;
      r_addr_q    <= '0;
      r_en_q      <= 1'b0;
      rgb1_q      <= '0;
      rgb2_q      <= '0;
      panel_clk_q <= 1'b0;
      latch_q     <= 1'b0;
      oe_n_q      <= 1'b1;
      row_out_q   <= '0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      col_q       <= col_d;
      row_q       <= row_d;
      plane_q     <= plane_d;
      on_cnt_q    <= on_cnt_d;
      lit_q       <= lit_d;
      r_addr_q    <= r_addr_d;
      r_en_q      <= r_en_d;
      rgb1_q      <= rgb1_d;
      rgb2_q      <= rgb2_d;
      panel_clk_q <= panel_clk_d;
      latch_q     <= latch_d;
      oe_n_q      <= oe_n_d;
      row_out_q   <= row_out_d;
      frame_q     <= frame_d;
    end
  end

  assign o_r_addr    = r_addr_q;
  assign o_r_enable  = r_en_q;
  assign {o_r1, o_g1, o_b1} = rgb1_q;
  assign {o_r2, o_g2, o_b2} = rgb2_q;
  assign o_panel_clk = panel_clk_q;
  assign o_latch     = latch_q;
  assign o_oe_n      = oe_n_q;
  assign o_row       = row_out_q;
  assign o_frame     = frame_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl
//   Directed bench for led_scan_ctrl with COLS=4, ROW_BITS=1, PLANES=2,
//   BASE_ON=2. The bench models the pixel RAM with a one-cycle read latency.
//   Plane lengths are 2 + 8 + 2 = 12 cycles for plane 0 and 2 + 8 + 4 = 14
//   cycles for plane 1. One frame of two rows is therefore 52 cycles.
//   Build with HUB75_BRIGHTNESS_EN to include the brightness scenario.
module tb_led_scan_ctrl;

  localparam int COLS = 4, ROW_BITS = 1, PLANES = 2, BASE_ON = 2;

  logic        clk, rst, enable;
  logic [2:0]  r_addr;
  logic        r_en;
  logic [15:0] d1, d2;
  logic        r1, g1, b1, r2, g2, b2;
  logic        panel_clk, latch, oe_n, frame;
  logic [0:0]  row;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif

  logic [15:0] mem1 [8];
  logic [15:0] mem2 [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Plane statistics gathered by measure_plane (observations only)
  int       m_rises, m_latch_cnt, m_latch_idx, m_oe_low, m_oe_first, m_reads, m_bad, m_frames;
  logic [2:0] m_rgb1_and, m_rgb1_or, m_rgb2_and, m_rgb2_or;
  logic [0:0] m_row_latch;

  led_scan_ctrl #(.COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES), .BASE_ON(BASE_ON)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
`ifdef HUB75_BRIGHTNESS_EN
    .i_brightness (brightness),
`endif
    .o_r_addr     (r_addr),
    .o_r_enable   (r_en),
    .i_bank1_data (d1),
    .i_bank2_data (d2),
    .o_r1         (r1),
    .o_g1         (g1),
    .o_b1         (b1),
    .o_r2         (r2),
    .o_g2         (g2),
    .o_b2         (b2),
    .o_panel_clk  (panel_clk),
    .o_latch      (latch),
    .o_oe_n       (oe_n),
    .o_row        (row),
    .o_frame      (frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel RAM: data for the address presented with r_en appears one cycle later
  initial begin
    d1 = '0;
    d2 = '0;
  end
  always @(posedge clk) begin
    if (r_en) begin
      d1 <= mem1[r_addr];
      d2 <= mem2[r_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Walks n samples starting at the current (PREFETCH) sample and records what the panel saw
  task automatic measure_plane(input int n, input int drop_at);
    logic       prev_clk;
    logic [0:0] prev_row;
    m_rises = 0; m_latch_cnt = 0; m_latch_idx = -1; m_oe_low = 0; m_oe_first = -1;
    m_reads = 0; m_bad = 0; m_frames = 0; m_row_latch = '0;
    m_rgb1_and = 3'b111; m_rgb1_or = 3'b000; m_rgb2_and = 3'b111; m_rgb2_or = 3'b000;
    prev_clk = panel_clk;
    prev_row = row;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      if (panel_clk && !prev_clk) begin
        m_rises++;
        m_rgb1_and &= {r1, g1, b1}; m_rgb1_or |= {r1, g1, b1};
        m_rgb2_and &= {r2, g2, b2}; m_rgb2_or |= {r2, g2, b2};
      end
      prev_clk = panel_clk;
      if (latch) begin
        m_latch_cnt++;
        if (m_latch_idx < 0) begin
          m_latch_idx = i;
          m_row_latch = row;
        end
      end
      if (!oe_n) begin
        m_oe_low++;
        if (m_oe_first < 0) m_oe_first = i;
      end
      if (!oe_n && latch) m_bad++;
      if (row !== prev_row && !latch) m_bad++;
      prev_row = row;
      if (r_en) m_reads++;
      if (frame) m_frames++;
      if (i == drop_at) enable = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({oe_n, r_en, r_addr, r1, g1, b1, r2, g2, b2, panel_clk, latch, row, frame} !== {1'b1, 14'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b want %b", {oe_n, r_en, r_addr, r1, g1, b1, r2, g2, b2, panel_clk, latch, row, frame}, {1'b1, 14'b0});
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({oe_n, r_en, r_addr, r1, g1, b1, r2, g2, b2, panel_clk, latch, row, frame} !== {1'b1, 14'b0}) begin
        n_fail++;
        $display("[TB] FAIL idle_outputs cycle %0d: got %b want %b", i, {oe_n, r_en, r_addr, r1, g1, b1, r2, g2, b2, panel_clk, latch, row, frame}, {1'b1, 14'b0});
      end
    end
  endtask

  task automatic test_full_white;
    for (int a = 0; a < 4; a++) begin
      mem1[a] = 16'hFFFF;
      mem2[a] = 16'h0000;
    end
    enable = 1'b1;
    tick();
    n_checks++;
    if ({r_en, r_addr, frame} !== 5'b1_000_0) begin
      n_fail++; $display("[TB] FAIL white_prefetch: got %b want %b", {r_en, r_addr, frame}, 5'b1_000_0);
    end
    measure_plane(12, -1);
    n_checks++;
    if (m_rises !== 4) begin n_fail++; $display("[TB] FAIL white_rises: got %0d want 4", m_rises); end
    n_checks++;
    if (m_rgb1_and !== 3'b111) begin n_fail++; $display("[TB] FAIL white_rgb1: got %b want 111", m_rgb1_and); end
    n_checks++;
    if (m_rgb2_or !== 3'b000) begin n_fail++; $display("[TB] FAIL white_rgb2: got %b want 000", m_rgb2_or); end
    n_checks++;
    if (m_latch_cnt !== 1 || m_latch_idx !== 9) begin
      n_fail++; $display("[TB] FAIL white_latch: got cnt %0d idx %0d want cnt 1 idx 9", m_latch_cnt, m_latch_idx);
    end
    n_checks++;
    if (m_oe_low !== 2 || m_oe_first !== 10) begin
      n_fail++; $display("[TB] FAIL white_oe: got low %0d first %0d want low 2 first 10", m_oe_low, m_oe_first);
    end
    n_checks++;
    if (m_row_latch !== 1'b0) begin n_fail++; $display("[TB] FAIL white_row: got %0d want 0", m_row_latch); end
    n_checks++;
    if (m_reads !== 4) begin n_fail++; $display("[TB] FAIL white_reads: got %0d want 4", m_reads); end
    n_checks++;
    if (m_bad !== 0) begin n_fail++; $display("[TB] FAIL white_row_or_lit_latch: got %0d want 0", m_bad); end
  endtask

  task automatic test_plane_bits;
    for (int a = 0; a < 4; a++) mem1[a] = 16'h0841;
    tick();
    n_checks++;
    if ({r_en, r_addr, frame} !== 5'b1_000_0) begin
      n_fail++; $display("[TB] FAIL bits_prefetch: got %b want %b", {r_en, r_addr, frame}, 5'b1_000_0);
    end
    measure_plane(14, -1);
    n_checks++;
    if (m_rises !== 4 || m_rgb1_or !== 3'b000 || m_rgb2_or !== 3'b000) begin
      n_fail++; $display("[TB] FAIL bits_plane1: got rises %0d rgb1 %b rgb2 %b want 4 000 000", m_rises, m_rgb1_or, m_rgb2_or);
    end
    n_checks++;
    if (m_oe_low !== 4 || m_oe_first !== 10 || m_latch_idx !== 9) begin
      n_fail++; $display("[TB] FAIL bits_window: got low %0d first %0d latch %0d want 4 10 9", m_oe_low, m_oe_first, m_latch_idx);
    end
  endtask

  task automatic test_frame_and_rows;
    int         cnt;
    int         nlat;
    int         bad;
    logic [3:0] rows_seen;
    logic [0:0] prev_row;
    for (int a = 4; a < 8; a++) begin
      mem1[a] = 16'h0841;
      mem2[a] = 16'hF7BE;
    end
    tick();
    n_checks++;
    if ({r_en, r_addr, frame} !== 5'b1_100_0) begin
      n_fail++; $display("[TB] FAIL row1_p0_prefetch: got %b want %b", {r_en, r_addr, frame}, 5'b1_100_0);
    end
    measure_plane(12, -1);
    n_checks++;
    if (m_rgb1_and !== 3'b111 || m_rgb2_or !== 3'b000 || m_row_latch !== 1'b1 || m_oe_low !== 2 || m_bad !== 0) begin
      n_fail++; $display("[TB] FAIL row1_p0: got rgb1 %b rgb2 %b row %0d oe %0d bad %0d want 111 000 1 2 0", m_rgb1_and, m_rgb2_or, m_row_latch, m_oe_low, m_bad);
    end
    tick();
    n_checks++;
    if ({r_en, r_addr, frame} !== 5'b1_100_0) begin
      n_fail++; $display("[TB] FAIL row1_p1_prefetch: got %b want %b", {r_en, r_addr, frame}, 5'b1_100_0);
    end
    measure_plane(14, -1);
    n_checks++;
    if (m_rgb1_or !== 3'b000 || m_rgb2_and !== 3'b111 || m_row_latch !== 1'b1 || m_oe_low !== 4 || m_frames !== 0) begin
      n_fail++; $display("[TB] FAIL row1_p1: got rgb1 %b rgb2 %b row %0d oe %0d frames %0d want 000 111 1 4 0", m_rgb1_or, m_rgb2_and, m_row_latch, m_oe_low, m_frames);
    end
    tick();
    n_checks++;
    if ({r_en, r_addr, frame} !== 5'b1_000_1) begin
      n_fail++; $display("[TB] FAIL frame_pulse: got %b want %b", {r_en, r_addr, frame}, 5'b1_000_1);
    end
    cnt = 0; nlat = 0; bad = 0; rows_seen = '0; prev_row = row;
    do begin
      tick();
      cnt++;
      if (latch) begin
        if (nlat < 4) rows_seen[nlat] = row;
        nlat++;
      end
      if (row !== prev_row && !latch) bad++;
      prev_row = row;
    end while (frame !== 1'b1 && cnt < 200);
    n_checks++;
    if (cnt !== 52) begin n_fail++; $display("[TB] FAIL frame_period: got %0d want 52", cnt); end
    n_checks++;
    if (nlat !== 4 || rows_seen !== 4'b1100) begin
      n_fail++; $display("[TB] FAIL row_sequence: got %0d latches rows %b want 4 1100", nlat, rows_seen);
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL row_change_outside_latch: got %0d want 0", bad); end
  endtask

  task automatic test_enable_drop;
    int viol;
    n_checks++;
    if ({r_en, r_addr} !== 4'b1_000) begin
      n_fail++; $display("[TB] FAIL drop_prefetch: got %b want %b", {r_en, r_addr}, 4'b1_000);
    end
    measure_plane(12, 3);
    n_checks++;
    if (m_rgb1_and !== 3'b111 || m_latch_cnt !== 1 || m_oe_low !== 2 || m_row_latch !== 1'b0) begin
      n_fail++; $display("[TB] FAIL drop_completes: got rgb1 %b latch %0d oe %0d row %0d want 111 1 2 0", m_rgb1_and, m_latch_cnt, m_oe_low, m_row_latch);
    end
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({r_en, oe_n, latch, panel_clk} !== 4'b0100) viol++;
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("[TB] FAIL drop_idle: got %0d active cycles want 0", viol); end
    enable = 1'b1;
    tick();
    n_checks++;
    if ({r_en, r_addr, frame} !== 5'b1_000_0) begin
      n_fail++; $display("[TB] FAIL resume_prefetch: got %b want %b", {r_en, r_addr, frame}, 5'b1_000_0);
    end
    measure_plane(14, -1);
    n_checks++;
    if (m_oe_low !== 4 || m_rgb1_or !== 3'b000 || m_row_latch !== 1'b0) begin
      n_fail++; $display("[TB] FAIL resume_plane1: got oe %0d rgb1 %b row %0d want 4 000 0", m_oe_low, m_rgb1_or, m_row_latch);
    end
  endtask

  task automatic test_reset_during_display;
    tick();
    n_checks++;
    if ({r_en, r_addr} !== 4'b1_100) begin
      n_fail++; $display("[TB] FAIL rst_setup_prefetch: got %b want %b", {r_en, r_addr}, 4'b1_100);
    end
    repeat (10) tick();
    n_checks++;
    if (oe_n !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_setup_lit: got %b want 0", oe_n); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({oe_n, r_en, r_addr, r1, g1, b1, r2, g2, b2, panel_clk, latch, row, frame} !== {1'b1, 14'b0}) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got %b want %b", {oe_n, r_en, r_addr, r1, g1, b1, r2, g2, b2, panel_clk, latch, row, frame}, {1'b1, 14'b0});
    end
    #2;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({r_en, r_addr, frame} !== 5'b1_000_0) begin
      n_fail++; $display("[TB] FAIL restart_prefetch: got %b want %b", {r_en, r_addr, frame}, 5'b1_000_0);
    end
    measure_plane(12, -1);
    n_checks++;
    if (m_oe_low !== 2 || m_rgb1_and !== 3'b111 || m_row_latch !== 1'b0) begin
      n_fail++; $display("[TB] FAIL restart_plane0: got oe %0d rgb1 %b row %0d want 2 111 0", m_oe_low, m_rgb1_and, m_row_latch);
    end
  endtask

`ifdef HUB75_BRIGHTNESS_EN
  task automatic test_brightness;
    brightness = 8'd127;
    tick();
    n_checks++;
    if ({r_en, r_addr} !== 4'b1_000) begin
      n_fail++; $display("[TB] FAIL bright_prefetch: got %b want %b", {r_en, r_addr}, 4'b1_000);
    end
    measure_plane(14, -1);
    n_checks++;
    if (m_oe_low !== 2 || m_oe_first !== 10 || m_latch_idx !== 9) begin
      n_fail++; $display("[TB] FAIL bright_oe: got low %0d first %0d latch %0d want 2 10 9", m_oe_low, m_oe_first, m_latch_idx);
    end
    tick();
    n_checks++;
    if ({r_en, r_addr} !== 4'b1_100) begin
      n_fail++; $display("[TB] FAIL bright_window_len: got %b want %b", {r_en, r_addr}, 4'b1_100);
    end
    brightness = 8'd255;
  endtask
`endif

  initial begin
    for (int a = 0; a < 8; a++) begin
      mem1[a] = '0;
      mem2[a] = '0;
    end
    rst = 1'b1;
    enable = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    $display("[TB] starting led_scan_ctrl bench");
    test_reset();
    test_full_white();
    test_plane_bits();
    test_frame_and_rows();
    test_enable_drop();
    test_reset_during_display();
`ifdef HUB75_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
